// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back cache controller.
package cache_pkg;

  localparam int ADDR_W          = 10;
  localparam int BYTE_OFF_W      = 2;
  localparam int WORD_OFF_W      = 2;
  localparam int BLOCK_OFF_W     = BYTE_OFF_W + WORD_OFF_W;
  localparam int WORD_W          = 32;
  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = BLOCK_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

  // Word 0 lives in the most significant slice of the block, word 3 in the least.
  function automatic int word_lsb(input logic [WORD_OFF_W-1:0] offset);
    return (WORDS_PER_BLOCK - 1 - int'(offset)) * WORD_W;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Per-line valid/dirty/tag/data storage with a combinational read port and a
// single synchronous write port (word store or full-block fill with tag).
module cache_line_store
  import cache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = ADDR_W - BLOCK_OFF_W - IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [BLOCK_W-1:0]    rd_data,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WORD_OFF_W-1:0] wr_offset,
  input  logic [WORD_W-1:0]     wr_word,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [BLOCK_W-1:0]    wr_block
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Next valid/dirty bits: a fill validates and cleans the line, a word store dirties it.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      if (wr_fill) begin
        valid_d[wr_idx] = 1'b1;
        dirty_d[wr_idx] = 1'b0;
      end else begin
        dirty_d[wr_idx] = 1'b1;
      end
    end
  end

  // Valid/dirty state register; reset empties the cache.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays; contents are meaningless while the line is invalid.
  // NOTE: storage arrays are deliberately not reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_fill) begin
        tag_q[wr_idx]  <= wr_tag;
        data_q[wr_idx] <= wr_block;
      end else begin
        data_q[wr_idx][word_lsb(wr_offset) +: WORD_W] <= wr_word;
      end
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: CPU word port on one
// side, registered 128-bit block interface to main memory on the other.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int NUM_LINES   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpuReq,
  input  logic                cpuWrite,
  input  logic [ADDR_W-1:0]   cpuAddress,
  input  logic [WORD_W-1:0]   cpuWriteData,
  output logic [WORD_W-1:0]   cpuReadData,
  output logic                cpuReady,
  output logic                isMemRead,
  output logic                isLock,
  output logic [ADDR_W-1:0]   memAddress,
  output logic [BLOCK_W-1:0]  memWriteData,
  input  logic [BLOCK_W-1:0]  memReadData
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - BLOCK_OFF_W - IDX_W;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  cache_state_t                 state_q, state_d;
  logic [ADDR_W-1:BYTE_OFF_W]   addr_q, addr_d;
  logic                         write_q, write_d;
  logic [WORD_W-1:0]            wdata_q, wdata_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         is_lock_q, is_lock_d;
  logic                         is_mem_read_q, is_mem_read_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]           mem_wdata_q, mem_wdata_d;
  logic                         cpu_ready_q, cpu_ready_d;
  logic [WORD_W-1:0]            cpu_rdata_q, cpu_rdata_d;

  logic                         byte_sel_unused;
  logic [TAG_W-1:0]             req_tag;
  logic [IDX_W-1:0]             req_idx;
  logic [WORD_OFF_W-1:0]        req_off;
  logic                         line_valid, line_dirty, hit, last_cycle;
  logic [TAG_W-1:0]             line_tag;
  logic [BLOCK_W-1:0]           line_data;
  logic                         ls_wr_en, ls_wr_fill;

  // Word accesses only: the byte lane bits carry no information.
  assign byte_sel_unused = ^cpuAddress[BYTE_OFF_W-1:0];

  assign req_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx    = addr_q[BLOCK_OFF_W +: IDX_W];
  assign req_off    = addr_q[BYTE_OFF_W +: WORD_OFF_W];
  assign hit        = line_valid && (line_tag == req_tag);
  assign last_cycle = (cnt_q == CNT_ONE);

  cache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (req_idx),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (ls_wr_en),
    .wr_fill   (ls_wr_fill),
    .wr_idx    (req_idx),
    .wr_offset (req_off),
    .wr_word   (wdata_q),
    .wr_tag    (req_tag),
    .wr_block  (memReadData)
  );

  // Next-state, request latching, memory-side register and line-store write decode.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    is_lock_d     = is_lock_q;
    is_mem_read_d = is_mem_read_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_ready_d   = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    ls_wr_en      = 1'b0;
    ls_wr_fill    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A request held across the ready pulse is not re-accepted in that cycle.
        if (cpuReq && !cpu_ready_q) begin
          addr_d  = cpuAddress[ADDR_W-1:BYTE_OFF_W];
          write_d = cpuWrite;
          wdata_d = cpuWriteData;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (hit) begin
          cpu_ready_d = 1'b1;
          state_d     = IDLE;
          if (write_q) begin
            ls_wr_en = 1'b1;
          end else begin
            cpu_rdata_d = line_data[word_lsb(req_off) +: WORD_W];
          end
        end else begin
          is_lock_d = 1'b0;
          cnt_d     = CNT_LOAD;
          if (line_valid && line_dirty) begin
            state_d       = WRITEBACK;
            is_mem_read_d = 1'b0;
            mem_addr_d    = {line_tag, req_idx, {BLOCK_OFF_W{1'b0}}};
            mem_wdata_d   = line_data;
          end else begin
            state_d       = ALLOCATE;
            is_mem_read_d = 1'b1;
            mem_addr_d    = {req_tag, req_idx, {BLOCK_OFF_W{1'b0}}};
          end
        end
      end

      WRITEBACK: begin
        if (last_cycle) begin
          // Direction and address flip on the same edge; isLock stays low.
          state_d       = ALLOCATE;
          cnt_d         = CNT_LOAD;
          is_mem_read_d = 1'b1;
          mem_addr_d    = {req_tag, req_idx, {BLOCK_OFF_W{1'b0}}};
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ALLOCATE: begin
        if (last_cycle) begin
          ls_wr_en   = 1'b1;
          ls_wr_fill = 1'b1;
          is_lock_d  = 1'b1;
          state_d    = COMPARE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset idles the memory port immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      is_lock_q     <= 1'b1;
      is_mem_read_q <= 1'b1;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      cpu_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      is_lock_q     <= is_lock_d;
      is_mem_read_q <= is_mem_read_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_rdata_q   <= cpu_rdata_d;
    end
  end

  assign cpuReadData  = cpu_rdata_q;
  assign cpuReady     = cpu_ready_q;
  assign isLock       = is_lock_q;
  assign isMemRead    = is_mem_read_q;
  assign memAddress   = mem_addr_q;
  assign memWriteData = mem_wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural block memory model.
module tb_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpuReq;
  logic         cpuWrite;
  logic [9:0]   cpuAddress;
  logic [31:0]  cpuWriteData;
  logic [31:0]  cpuReadData;
  logic         cpuReady;
  logic         isMemRead;
  logic         isLock;
  logic [9:0]   memAddress;
  logic [127:0] memWriteData;
  logic [127:0] memReadData;

  int checks = 0;
  int errors = 0;
  int proto_err = 0;

  always #5 clk = ~clk;

  cache_ctrl #(
    .MEM_LATENCY (4),
    .NUM_LINES   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpuReq       (cpuReq),
    .cpuWrite     (cpuWrite),
    .cpuAddress   (cpuAddress),
    .cpuWriteData (cpuWriteData),
    .cpuReadData  (cpuReadData),
    .cpuReady     (cpuReady),
    .isMemRead    (isMemRead),
    .isLock       (isLock),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memReadData  (memReadData)
  );

  // Block memory: combinational read, write whenever isLock=0 and isMemRead=0.
  logic [127:0] mem [64];
  assign memReadData = mem[memAddress[9:4]];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[6'h00] = {32'h0000_3cc3, 96'h0};
    mem[6'h20] = {32'h0000_0ccc, 96'h0};
    mem[6'h30] = {32'h0000_00c3, 96'h0};
    forever begin
      @(negedge clk);
      if (rst_n && !isLock && !isMemRead) mem[memAddress[9:4]] = memWriteData;
    end
  end

  // Protocol monitor: idle port must read, block addresses are aligned.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (isLock && !isMemRead) proto_err++;
      if (memAddress[3:0] != 4'h0) proto_err++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, and observe the
  // memory port until cpuReady (bounded).
  task automatic do_req(input logic wr, input logic [9:0] a, input logic [31:0] d,
                        output int cyc, output int wb, output int al,
                        output logic [31:0] rd, output logic [9:0] wb_addr,
                        output logic [31:0] wb_word, output logic [9:0] al_addr);
    cyc = 0; wb = 0; al = 0; rd = '0; wb_addr = '0; wb_word = '0; al_addr = '0;
    @(negedge clk);
    cpuReq = 1'b1; cpuWrite = wr; cpuAddress = a; cpuWriteData = d;
    @(posedge clk);
    #1;
    cpuReq = 1'b0; cpuWrite = ~wr; cpuAddress = ~a; cpuWriteData = ~d;
    do begin
      @(negedge clk);
      cyc++;
      if (!isLock) begin
        if (!isMemRead) begin
          wb++; wb_addr = memAddress; wb_word = memWriteData[95:64];
        end else begin
          al++; al_addr = memAddress;
        end
      end
    end while (!cpuReady && cyc < 100);
    rd = cpuReadData;
    @(posedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_cyc;
    int          exp_wb;
    int          exp_al;
    logic [9:0]  exp_wb_addr;
    logic [31:0] exp_wb_word;
    logic [9:0]  exp_al_addr;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int cyc, wb, al, pulses, b2b, bad, seen;
    logic [31:0] rd, wb_word;
    logic [9:0] wb_addr, al_addr;
    logic prev;

    //            wr    addr    wdata         chk   exp_rd        cyc wb al wb_addr wb_word       al_addr
    vecs[0]  = '{1'b0, 10'h000, 32'h0,        1'b1, 32'h0000_3cc3, 7, 0, 4, 10'h000, 32'h0,        10'h000};
    vecs[1]  = '{1'b0, 10'h000, 32'h0,        1'b1, 32'h0000_3cc3, 2, 0, 0, 10'h000, 32'h0,        10'h000};
    vecs[2]  = '{1'b1, 10'h004, 32'hdeadbeef, 1'b0, 32'h0,         2, 0, 0, 10'h000, 32'h0,        10'h000};
    vecs[3]  = '{1'b0, 10'h200, 32'h0,        1'b1, 32'h0000_0ccc, 11, 4, 4, 10'h000, 32'hdeadbeef, 10'h200};
    vecs[4]  = '{1'b0, 10'h300, 32'h0,        1'b1, 32'h0000_00c3, 7, 0, 4, 10'h000, 32'h0,        10'h300};
    vecs[5]  = '{1'b0, 10'h004, 32'h0,        1'b1, 32'hdeadbeef,  7, 0, 4, 10'h000, 32'h0,        10'h000};
    vecs[6]  = '{1'b0, 10'h008, 32'h0,        1'b1, 32'h0,         2, 0, 0, 10'h000, 32'h0,        10'h000};
    vecs[7]  = '{1'b1, 10'h014, 32'h11112222, 1'b0, 32'h0,         7, 0, 4, 10'h000, 32'h0,        10'h010};
    vecs[8]  = '{1'b0, 10'h01c, 32'h0,        1'b1, 32'h0,         2, 0, 0, 10'h000, 32'h0,        10'h000};
    vecs[9]  = '{1'b0, 10'h014, 32'h0,        1'b1, 32'h11112222,  2, 0, 0, 10'h000, 32'h0,        10'h000};
    vecs[10] = '{1'b1, 10'h000, 32'h0000_0055, 1'b0, 32'h0,        2, 0, 0, 10'h000, 32'h0,        10'h000};

    rst_n = 1'b0; cpuReq = 1'b0; cpuWrite = 1'b0; cpuAddress = '0; cpuWriteData = '0;
    repeat (3) @(negedge clk);
    check("rst_isLock",       32'(isLock), 32'd1);
    check("rst_isMemRead",    32'(isMemRead), 32'd1);
    check("rst_memAddress",   32'(memAddress), 32'd0);
    check("rst_memWriteData", 32'(|memWriteData), 32'd0);
    check("rst_cpuReady",     32'(cpuReady), 32'd0);
    check("rst_cpuReadData",  cpuReadData, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, cyc, wb, al, rd, wb_addr, wb_word, al_addr);
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
      check($sformatf("v%0d_wb_cycles", i), wb, vecs[i].exp_wb);
      check($sformatf("v%0d_alloc_cycles", i), al, vecs[i].exp_al);
      if (vecs[i].exp_wb > 0) begin
        check($sformatf("v%0d_wb_addr", i), 32'(wb_addr), 32'(vecs[i].exp_wb_addr));
        check($sformatf("v%0d_wb_word", i), wb_word, vecs[i].exp_wb_word);
      end
      if (vecs[i].exp_al > 0)
        check($sformatf("v%0d_alloc_addr", i), 32'(al_addr), 32'(vecs[i].exp_al_addr));
    end

    // Reset during the second writeback cycle of a dirty miss.
    @(negedge clk);
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = 10'h200;
    @(posedge clk);
    #1 cpuReq = 1'b0;
    @(negedge clk);
    check("rstwb_compare_lock", 32'(isLock), 32'd1);
    @(negedge clk);
    check("rstwb_wb1_lock", 32'(isLock), 32'd0);
    @(negedge clk);
    check("rstwb_wb2_read", 32'(isMemRead), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstwb_async_lock", 32'(isLock), 32'd1);
    check("rstwb_async_read", 32'(isMemRead), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpuReady) seen++;
    end
    check("rstwb_no_stale_ready", seen, 0);
    @(posedge clk);
    do_req(1'b0, 10'h200, 32'h0, cyc, wb, al, rd, wb_addr, wb_word, al_addr);
    check("post_rst_cycles", cyc, 7);
    check("post_rst_wb", wb, 0);
    check("post_rst_alloc", al, 4);
    check("post_rst_rdata", rd, 32'h0000_0ccc);

    // cpuReq held high with a constant hit address: one pulse per accepted request.
    @(negedge clk);
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddress = 10'h200;
    pulses = 0; b2b = 0; bad = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpuReady) begin
        pulses++;
        if (cpuReadData !== 32'h0000_0ccc) bad++;
        if (prev) b2b++;
      end
      prev = cpuReady;
    end
    cpuReq = 1'b0;
    check("hold_req_pulses", pulses, 4);
    check("hold_req_back_to_back", b2b, 0);
    check("hold_req_rdata", bad, 0);

    repeat (3) @(negedge clk);
    check("protocol_violations", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
